strip_xg_pon_header: RTL and testbench

// Burst-receive counterpart of the XG-PON header inserter. Hunts the 32-bit AXIS stream for the

---
 rtl/strip_xg_pon_header_if.sv | 13 +
 rtl/strip_xg_pon_header.sv | 125 ++++++++++++
 tb/tb_strip_xg_pon_header.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/strip_xg_pon_header_if.sv
// AXI4-Stream bundle (32-bit data, byte keep, last, user) shared by the header
// stripper's input and output sides.
interface strip_xg_pon_header_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic [3:0]  tkeep;
   logic        tlast;
   logic        tuser;
   logic        tready;

   modport master (output tdata, tvalid, tkeep, tlast, tuser, input tready);
   modport slave  (input tdata, tvalid, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/strip_xg_pon_header.sv
// XG-PON burst receive: hunts for the preamble, locks on a (bit-error tolerant)
// delimiter, strips both and forwards the payload through one output register.
module strip_xg_pon_header #(
   parameter int          MIN_PREAMBLE  = 2,
   parameter int          DELIM_ERR_TOL = 2,
   parameter logic [31:0] PREAMBLE_WORD = 32'h05560556,
   parameter logic [31:0] DELIM_WORD    = 32'hb2c50fa1
) (
   input  logic                          axis_clk,
   input  logic                          axis_resetn,
   strip_xg_pon_header_if.slave          s_axis,
   strip_xg_pon_header_if.master         m_axis,
   output logic                          burst_locked,
   output logic [15:0]                   burst_cnt,
   output logic [15:0]                   hdr_err_cnt
);

   typedef enum logic [1:0] {HUNT, PREAMBLE, PAYLOAD} state_t;

   localparam logic [3:0] MIN_P   = 4'(MIN_PREAMBLE);
   localparam logic [5:0] ERR_TOL = 6'(DELIM_ERR_TOL);

   function automatic logic [5:0] bit_errs(input logic [31:0] w);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + {5'd0, w[i]};
      return n;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   state_t      state;
   logic [3:0]  pcnt;
   logic [31:0] data_p1;
   logic [3:0]  keep_p1;
   logic        last_p1;
   logic        user_p1;
   logic        vld_p1;
   logic        in_beat;
   logic        pay_beat;
   logic        is_pre;
   logic        is_delim;

   // Header words are always swallowed; payload is throttled by the output register.
   assign s_axis.tready = (state == PAYLOAD) ? (!vld_p1 || m_axis.tready) : 1'b1;
   assign in_beat       = s_axis.tvalid && s_axis.tready;
   assign pay_beat      = in_beat && (state == PAYLOAD);
   assign is_pre        = (s_axis.tdata == PREAMBLE_WORD);
   assign is_delim      = (bit_errs(s_axis.tdata ^ DELIM_WORD) <= ERR_TOL);

   assign m_axis.tdata  = data_p1;
   assign m_axis.tkeep  = keep_p1;
   assign m_axis.tlast  = last_p1;
   assign m_axis.tuser  = user_p1;
   assign m_axis.tvalid = vld_p1;

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state        <= HUNT;
         pcnt         <= '0;
         burst_locked <= 1'b0;
         burst_cnt    <= '0;
         hdr_err_cnt  <= '0;
         data_p1      <= '0;
         keep_p1      <= '0;
         last_p1      <= 1'b0;
         user_p1      <= 1'b0;
         vld_p1       <= 1'b0;
      end else begin
         // Output register stage (_p1)
         if (pay_beat) begin
            data_p1 <= s_axis.tdata;
            keep_p1 <= s_axis.tkeep;
            last_p1 <= s_axis.tlast;
            user_p1 <= s_axis.tuser;
            vld_p1  <= 1'b1;
         end else if (m_axis.tready) begin
            vld_p1  <= 1'b0;
         end

         case (state)
            HUNT: begin
               if (in_beat && is_pre && !s_axis.tlast) begin
                  state <= PREAMBLE;
                  pcnt  <= 4'd1;
               end
            end
            PREAMBLE: begin
               if (in_beat) begin
                  if (s_axis.tlast) begin
                     state       <= HUNT;
                     hdr_err_cnt <= sat_inc16(hdr_err_cnt);
                  end else if (is_pre) begin
                     pcnt <= sat_inc4(pcnt);
                  end else if (is_delim && (pcnt >= MIN_P)) begin
                     state        <= PAYLOAD;
                     burst_locked <= 1'b1;
                     burst_cnt    <= sat_inc16(burst_cnt);
                  end else begin
                     state       <= HUNT;
                     hdr_err_cnt <= sat_inc16(hdr_err_cnt);
                  end
               end
            end
            PAYLOAD: begin
               if (pay_beat && s_axis.tlast) begin
                  state        <= HUNT;
                  burst_locked <= 1'b0;
               end
            end
            default: begin
               state        <= HUNT;
               burst_locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_strip_xg_pon_header.sv
// Directed bench for strip_xg_pon_header: header stripping, delimiter error
// tolerance, back-pressure, back-to-back bursts and mid-burst reset.
module tb_strip_xg_pon_header;

   localparam logic [31:0] P = 32'h05560556;
   localparam logic [31:0] D = 32'hb2c50fa1;

   logic        clk;
   logic        rst_n;
   logic        toggle_rdy;
   logic [15:0] burst_cnt;
   logic [15:0] hdr_err_cnt;
   logic        burst_locked;
   int          checks;
   int          errors;
   logic [32:0] q[$];
   logic        stalled;
   logic [31:0] held;

   strip_xg_pon_header_if s_if ();
   strip_xg_pon_header_if m_if ();

   strip_xg_pon_header dut (
      .axis_clk     (clk),
      .axis_resetn  (rst_n),
      .s_axis       (s_if.slave),
      .m_axis       (m_if.master),
      .burst_locked (burst_locked),
      .burst_cnt    (burst_cnt),
      .hdr_err_cnt  (hdr_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_rdy) m_if.tready = ~m_if.tready;
   endtask

   task automatic beat(input logic [31:0] data, input logic last = 1'b0,
                       input logic [3:0] keep = 4'hF, input logic user = 1'b0);
      logic acc;
      s_if.tdata  = data;
      s_if.tlast  = last;
      s_if.tkeep  = keep;
      s_if.tuser  = user;
      s_if.tvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         acc = s_if.tready;
         tick();
         if (acc) return;
      end
      chk("beat_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle();
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   task automatic hdr(input logic [31:0] delim);
      beat(P);
      beat(P);
      beat(delim);
   endtask

   // Collects every output handshake and watches that stalled data stays put.
   always @(negedge clk) begin
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) chk("stall_stable", {32'd0, m_if.tdata}, {32'd0, held});
         if (m_if.tvalid && m_if.tready) q.push_back({m_if.tlast, m_if.tdata});
         stalled = m_if.tvalid && !m_if.tready;
         held    = m_if.tdata;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      toggle_rdy  = 1'b0;
      rst_n       = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", {63'd0, m_if.tvalid}, 64'd0);
      chk("rst_tdata", {32'd0, m_if.tdata}, 64'd0);
      chk("rst_cnts", {32'd0, burst_cnt, hdr_err_cnt}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: basic burst, one cycle latency
      beat(P); beat(P);
      chk("t1_pre_tvalid", {63'd0, m_if.tvalid}, 64'd0);
      beat(P); beat(D);
      chk("t1_locked", {63'd0, burst_locked}, 64'd1);
      beat(32'h11111111);
      chk("t1_w0", {31'd0, m_if.tvalid, m_if.tlast, m_if.tdata}, {31'd0, 1'b1, 1'b0, 32'h11111111});
      beat(32'h22222222);
      chk("t1_w1", {31'd0, m_if.tvalid, m_if.tlast, m_if.tdata}, {31'd0, 1'b1, 1'b0, 32'h22222222});
      beat(32'h33333333, 1'b1);
      idle();
      chk("t1_w2", {31'd0, m_if.tvalid, m_if.tlast, m_if.tdata}, {31'd0, 1'b1, 1'b1, 32'h33333333});
      chk("t1_unlocked", {63'd0, burst_locked}, 64'd0);
      chk("t1_burst_cnt", {48'd0, burst_cnt}, 64'd1);
      tick();
      chk("t1_drained", {63'd0, m_if.tvalid}, 64'd0);

      // 2: delimiter after a single preamble is a header error
      beat(P); beat(D);
      chk("t2_err_cnt", {48'd0, hdr_err_cnt}, 64'd1);
      chk("t2_unlocked", {63'd0, burst_locked}, 64'd0);
      beat(32'hAAAA0000, 1'b1);
      idle();
      tick();
      chk("t2_no_out", {63'd0, m_if.tvalid}, 64'd0);

      // 3: delimiter bit-error tolerance boundary
      hdr(32'hb2c50fa3);
      chk("t3_1bit_lock", {47'd0, burst_locked, burst_cnt}, {47'd0, 1'b1, 16'd2});
      beat(32'h44444444, 1'b1, 4'h3, 1'b1);
      idle();
      chk("t3_verbatim", {26'd0, m_if.tuser, m_if.tkeep, m_if.tlast, m_if.tdata},
          {26'd0, 1'b1, 4'h3, 1'b1, 32'h44444444});
      hdr(32'hb2c50f5e);
      idle();
      chk("t3_8bit_err", {47'd0, burst_locked, hdr_err_cnt}, {47'd0, 1'b0, 16'd2});
      hdr(32'hb2c50fa7);
      chk("t3_2bit_lock", {48'd0, burst_cnt}, 64'd3);
      beat(32'h55555555, 1'b1);
      idle();
      chk("t3_2bit_data", {32'd0, m_if.tdata}, 64'h55555555);
      hdr(32'hb2c50faf);
      idle();
      chk("t3_3bit_err", {48'd0, hdr_err_cnt}, 64'd3);
      beat(P); beat(P, 1'b1);
      idle();
      chk("t3_tlast_hdr_err", {47'd0, burst_locked, hdr_err_cnt}, {47'd0, 1'b0, 16'd4});

      // 4: eight words under toggling back-pressure
      tick();
      q.delete();
      toggle_rdy = 1'b1;
      hdr(D);
      for (int i = 1; i <= 8; i++) beat(32'h80000000 | i, (i == 8));
      idle();
      repeat (20) tick();
      toggle_rdy  = 1'b0;
      m_if.tready = 1'b1;
      chk("t4_count", 64'(q.size()), 64'd8);
      for (int i = 0; i < 8 && i < q.size(); i++)
         chk("t4_word", {31'd0, q[i]}, {31'd0, (i == 7), 32'h80000001 + 32'(i)});
      chk("t4_burst_cnt", {48'd0, burst_cnt}, 64'd4);

      // 5: back-to-back bursts, preamble right after TLAST
      q.delete();
      hdr(D);
      beat(32'hA1A1A1A1);
      beat(32'hA2A2A2A2, 1'b1);
      hdr(D);
      beat(32'hB1B1B1B1, 1'b1);
      idle();
      repeat (3) tick();
      chk("t5_count", 64'(q.size()), 64'd3);
      if (q.size() == 3) begin
         chk("t5_a1", {31'd0, q[0]}, {31'd0, 1'b0, 32'hA1A1A1A1});
         chk("t5_a2", {31'd0, q[1]}, {31'd0, 1'b1, 32'hA2A2A2A2});
         chk("t5_b1", {31'd0, q[2]}, {31'd0, 1'b1, 32'hB1B1B1B1});
      end
      chk("t5_cnts", {32'd0, burst_cnt, hdr_err_cnt}, {32'd0, 16'd6, 16'd4});

      // 6: asynchronous reset mid-payload
      hdr(D);
      beat(32'hC1C1C1C1);
      beat(32'hC2C2C2C2);
      chk("t6_pre_rst", {63'd0, m_if.tvalid}, 64'd1);
      #2 rst_n = 1'b0;
      idle();
      #1;
      chk("t6_rst_out", {30'd0, m_if.tvalid, burst_locked, m_if.tdata}, 64'd0);
      chk("t6_rst_cnts", {32'd0, burst_cnt, hdr_err_cnt}, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
      beat(32'hdeadbeef);
      idle();
      tick();
      chk("t6_junk", {46'd0, m_if.tvalid, burst_locked, hdr_err_cnt}, 64'd0);
      hdr(D);
      beat(32'hD1D1D1D1, 1'b1);
      idle();
      chk("t6_relock", {15'd0, m_if.tvalid, burst_cnt, m_if.tdata}, {15'd0, 1'b1, 16'd1, 32'hD1D1D1D1});
      repeat (2) tick();
      chk("t6_q", 64'(q.size()), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
